// File: rtl/video_link_pkg.sv
// Shared definitions for the GT/SFP video packet link (sender and receiver).
// Holds the K-word constants, the receiver state enum and the word classifier.
package video_link_pkg;

    localparam logic [7:0]  K_CHAR   = 8'hBC;
    localparam logic [3:0]  K_CTRL   = 4'b0001;
    localparam logic [3:0]  D_CTRL   = 4'b0000;

    localparam logic [31:0] K_SYNC0  = 32'hFF00_00BC;
    localparam logic [31:0] K_SYNC1  = 32'hFF00_01BC;
    localparam logic [31:0] K_LSTART = 32'hFF00_02BC;
    localparam logic [31:0] K_LEND   = 32'hFF00_03BC;
    localparam logic [31:0] K_IDLE0  = 32'hFF55_55BC;
    localparam logic [31:0] K_IDLE1  = 32'hFFAA_AABC;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_GOT_S0    = 2'd1,
        ST_WAIT_LINE = 2'd2,
        ST_LINE      = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        WC_DATA      = 3'd0,
        WC_SYNC0     = 3'd1,
        WC_SYNC1     = 3'd2,
        WC_LSTART    = 3'd3,
        WC_LEND      = 3'd4,
        WC_IDLE      = 3'd5,
        WC_UNKNOWN_K = 3'd6
    } word_class_t;

    // Classify one received word. Only a single K byte in byte0 forms a valid
    // control word; anything else carrying a K flag is unknown.
    function automatic word_class_t classify_word(input logic [31:0] data,
                                                  input logic [3:0]  ctrl);
        word_class_t cls;
        if (ctrl == D_CTRL) begin
            cls = WC_DATA;
        end else if (ctrl != K_CTRL) begin
            cls = WC_UNKNOWN_K;
        end else begin
            case (data)
                K_SYNC0:          cls = WC_SYNC0;
                K_SYNC1:          cls = WC_SYNC1;
                K_LSTART:         cls = WC_LSTART;
                K_LEND:           cls = WC_LEND;
                K_IDLE0, K_IDLE1: cls = WC_IDLE;
                default:          cls = WC_UNKNOWN_K;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/gt_word_align.sv
// Byte alignment stage for the GT receive stream (used when VIDEO_RECV_ALIGN_EN
// is defined). Locks the byte offset of the K character from IDLE words and
// rebuilds each word from the previous word's upper bytes and the current
// word's lower bytes so the K byte lands in byte0. One cycle of latency.
module gt_word_align
    import video_link_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_ctrl,
    output logic [31:0] out_data,
    output logic [3:0]  out_ctrl
);

    logic [31:0] prev_data_r;
    logic [3:0]  prev_ctrl_r;
    logic [1:0]  offs_r;
    logic [31:0] out_data_r;
    logic [3:0]  out_ctrl_r;

    logic [1:0]  offs_nxt_s;
    logic        hit_s;
    logic [31:0] aligned_data_s;
    logic [3:0]  aligned_ctrl_s;

    function automatic logic [31:0] rebuild_data(input logic [31:0] prev,
                                                 input logic [31:0] cur,
                                                 input logic [1:0]  offs);
        logic [31:0] w;
        case (offs)
            2'd0:    w = cur;
            2'd1:    w = {cur[7:0],  prev[31:8]};
            2'd2:    w = {cur[15:0], prev[31:16]};
            2'd3:    w = {cur[23:0], prev[31:24]};
            default: w = cur;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] rebuild_ctrl(input logic [3:0] prev,
                                                input logic [3:0] cur,
                                                input logic [1:0] offs);
        logic [3:0] c;
        case (offs)
            2'd0:    c = cur;
            2'd1:    c = {cur[0],   prev[3:1]};
            2'd2:    c = {cur[1:0], prev[3:2]};
            2'd3:    c = {cur[2:0], prev[3]};
            default: c = cur;
        endcase
        return c;
    endfunction

    function automatic logic is_idle(input logic [31:0] data, input logic [3:0] ctrl);
        return (ctrl == K_CTRL) && ((data == K_IDLE0) || (data == K_IDLE1));
    endfunction

    // Search all four offsets for a complete IDLE word and rebuild with the winning offset.
    always_comb begin
        offs_nxt_s = offs_r;
        hit_s      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!hit_s && is_idle(rebuild_data(prev_data_r, in_data, 2'(k)),
                                  rebuild_ctrl(prev_ctrl_r, in_ctrl, 2'(k)))) begin
                offs_nxt_s = 2'(k);
                hit_s      = 1'b1;
            end else begin
                hit_s      = hit_s;
            end
        end
        aligned_data_s = rebuild_data(prev_data_r, in_data, offs_nxt_s);
        aligned_ctrl_s = rebuild_ctrl(prev_ctrl_r, in_ctrl, offs_nxt_s);
    end

    // Hold the previous word, the locked offset and the registered aligned word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_data_r <= 32'h0000_0000;
            prev_ctrl_r <= 4'b0000;
            offs_r      <= 2'd0;
            out_data_r  <= 32'h0000_0000;
            out_ctrl_r  <= 4'b0000;
        end else begin
            prev_data_r <= in_data;
            prev_ctrl_r <= in_ctrl;
            offs_r      <= offs_nxt_s;
            out_data_r  <= aligned_data_s;
            out_ctrl_r  <= aligned_ctrl_s;
        end
    end

    assign out_data = out_data_r;
    assign out_ctrl = out_ctrl_r;

endmodule

// File: rtl/video_packet_recv.sv
// Video packet receiver for the GT/SFP link (rx_clk domain).
// Decodes frame-sync / line-start / line-end / idle K-words into a registered
// pixel-pair stream with frame and line strobes, line counting and error
// accounting. Optional macro VIDEO_RECV_ALIGN_EN inserts the gt_word_align
// byte-alignment stage ahead of decode (one extra cycle of latency).
module video_packet_recv
    import video_link_pkg::*;
#(
    parameter int WIDTH_W     = 16,
    parameter int ERR_CNT_SAT = 1
)(
    input  logic               rx_clk,
    input  logic               rst_n,
    input  logic [31:0]        gt_rx_data,
    input  logic [3:0]         gt_rx_ctrl,
    input  logic [WIDTH_W-1:0] vin_width,
    output logic               frame_start,
    output logic               line_start,
    output logic               line_end,
    output logic               vout_de,
    output logic [31:0]        vout_data,
    output logic [WIDTH_W-1:0] line_cnt,
    output logic               len_err,
    output logic [WIDTH_W-1:0] err_cnt
);

    localparam logic [WIDTH_W-1:0] CNT_ONE  = {{(WIDTH_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_W-1:0] CNT_ZERO = {WIDTH_W{1'b0}};
    localparam logic [WIDTH_W-1:0] CNT_MAX  = {WIDTH_W{1'b1}};

    logic [31:0] dec_data_s;
    logic [3:0]  dec_ctrl_s;

`ifdef VIDEO_RECV_ALIGN_EN
    gt_word_align u_align (
        .clk      (rx_clk),
        .rst_n    (rst_n),
        .in_data  (gt_rx_data),
        .in_ctrl  (gt_rx_ctrl),
        .out_data (dec_data_s),
        .out_ctrl (dec_ctrl_s)
    );
`else
    assign dec_data_s = gt_rx_data;
    assign dec_ctrl_s = gt_rx_ctrl;
`endif

    rx_state_t          state_r, state_nxt_s;
    logic               frame_start_r, line_start_r, line_end_r, vout_de_r, len_err_r;
    logic [31:0]        vout_data_r;
    logic [WIDTH_W-1:0] line_cnt_r, err_cnt_r, word_cnt_r;

    logic               frame_start_nxt_s, line_start_nxt_s, line_end_nxt_s;
    logic               vout_de_nxt_s, len_err_nxt_s, err_inc_s;
    logic [31:0]        vout_data_nxt_s;
    logic [WIDTH_W-1:0] line_cnt_nxt_s, err_cnt_nxt_s, word_cnt_nxt_s;
    logic [WIDTH_W-1:0] half_width_s;
    word_class_t        word_class_s;

    assign word_class_s = classify_word(dec_data_s, dec_ctrl_s);
    assign half_width_s = {1'b0, vin_width[WIDTH_W-1:1]};

    // Next-state and next-output decode of the current word.
    always_comb begin
        state_nxt_s       = state_r;
        frame_start_nxt_s = 1'b0;
        line_start_nxt_s  = 1'b0;
        line_end_nxt_s    = 1'b0;
        vout_de_nxt_s     = 1'b0;
        vout_data_nxt_s   = vout_data_r;
        len_err_nxt_s     = 1'b0;
        err_inc_s         = 1'b0;
        line_cnt_nxt_s    = line_cnt_r;
        word_cnt_nxt_s    = word_cnt_r;
        case (state_r)
            ST_SEARCH: begin
                if (word_class_s == WC_SYNC0) begin
                    state_nxt_s = ST_GOT_S0;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_GOT_S0: begin
                case (word_class_s)
                    WC_SYNC1: begin
                        frame_start_nxt_s = 1'b1;
                        line_cnt_nxt_s    = CNT_ZERO;
                        state_nxt_s       = ST_WAIT_LINE;
                    end
                    WC_SYNC0: state_nxt_s = ST_GOT_S0;
                    default:  state_nxt_s = ST_SEARCH;
                endcase
            end
            ST_WAIT_LINE: begin
                case (word_class_s)
                    WC_LSTART: begin
                        line_start_nxt_s = 1'b1;
                        word_cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s      = ST_LINE;
                    end
                    WC_DATA:  err_inc_s   = 1'b1;
                    WC_SYNC0: state_nxt_s = ST_GOT_S0;
                    default:  state_nxt_s = ST_WAIT_LINE;
                endcase
            end
            ST_LINE: begin
                case (word_class_s)
                    WC_DATA: begin
                        vout_de_nxt_s   = 1'b1;
                        vout_data_nxt_s = dec_data_s;
                        if (word_cnt_r != CNT_MAX) begin
                            word_cnt_nxt_s = word_cnt_r + CNT_ONE;
                        end else begin
                            word_cnt_nxt_s = word_cnt_r;
                        end
                    end
                    WC_LEND: begin
                        line_end_nxt_s = 1'b1;
                        line_cnt_nxt_s = line_cnt_r + CNT_ONE;
                        state_nxt_s    = ST_WAIT_LINE;
                        if (word_cnt_r != half_width_s) begin
                            len_err_nxt_s = 1'b1;
                            err_inc_s     = 1'b1;
                        end else begin
                            len_err_nxt_s = 1'b0;
                        end
                    end
                    WC_SYNC0: begin
                        // Frame resync mid-line: the partial line is an error.
                        len_err_nxt_s = 1'b1;
                        err_inc_s     = 1'b1;
                        state_nxt_s   = ST_GOT_S0;
                    end
                    default: begin
                        len_err_nxt_s = 1'b1;
                        err_inc_s     = 1'b1;
                        state_nxt_s   = ST_WAIT_LINE;
                    end
                endcase
            end
            default: state_nxt_s = ST_SEARCH;
        endcase
    end

    // Error counter update: single increment per cycle, saturating or wrapping.
    always_comb begin
        err_cnt_nxt_s = err_cnt_r;
        if (err_inc_s) begin
            if ((ERR_CNT_SAT != 32'sd0) && (err_cnt_r == CNT_MAX)) begin
                err_cnt_nxt_s = err_cnt_r;
            end else begin
                err_cnt_nxt_s = err_cnt_r + CNT_ONE;
            end
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end
    end

    // State register and all registered outputs/counters.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_SEARCH;
            frame_start_r <= 1'b0;
            line_start_r  <= 1'b0;
            line_end_r    <= 1'b0;
            vout_de_r     <= 1'b0;
            vout_data_r   <= 32'h0000_0000;
            len_err_r     <= 1'b0;
            line_cnt_r    <= CNT_ZERO;
            err_cnt_r     <= CNT_ZERO;
            word_cnt_r    <= CNT_ZERO;
        end else begin
            state_r       <= state_nxt_s;
            frame_start_r <= frame_start_nxt_s;
            line_start_r  <= line_start_nxt_s;
            line_end_r    <= line_end_nxt_s;
            vout_de_r     <= vout_de_nxt_s;
            vout_data_r   <= vout_data_nxt_s;
            len_err_r     <= len_err_nxt_s;
            line_cnt_r    <= line_cnt_nxt_s;
            err_cnt_r     <= err_cnt_nxt_s;
            word_cnt_r    <= word_cnt_nxt_s;
        end
    end

    assign frame_start = frame_start_r;
    assign line_start  = line_start_r;
    assign line_end    = line_end_r;
    assign vout_de     = vout_de_r;
    assign vout_data   = vout_data_r;
    assign len_err     = len_err_r;
    assign line_cnt    = line_cnt_r;
    assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_video_packet_recv.sv
// Directed self-checking bench for video_packet_recv. Outputs are recorded on
// every falling edge into history arrays; each test then checks the entries
// for the words it sent.
module tb_video_packet_recv;

`ifdef VIDEO_RECV_ALIGN_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] W_SYNC0  = 32'hFF0000BC;
    localparam logic [31:0] W_SYNC1  = 32'hFF0001BC;
    localparam logic [31:0] W_LSTART = 32'hFF0002BC;
    localparam logic [31:0] W_LEND   = 32'hFF0003BC;
    localparam logic [31:0] W_IDLE0  = 32'hFF5555BC;
    localparam logic [3:0]  CK = 4'b0001;
    localparam logic [3:0]  CD = 4'b0000;

    logic        rx_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] gt_rx_data = 32'h0;
    logic [3:0]  gt_rx_ctrl = 4'h0;
    logic [15:0] vin_width  = 16'd8;
    logic        frame_start, line_start, line_end, vout_de, len_err;
    logic [31:0] vout_data;
    logic [15:0] line_cnt, err_cnt;

    video_packet_recv #(.WIDTH_W(16), .ERR_CNT_SAT(1)) dut (
        .rx_clk(rx_clk), .rst_n(rst_n), .gt_rx_data(gt_rx_data), .gt_rx_ctrl(gt_rx_ctrl),
        .vin_width(vin_width), .frame_start(frame_start), .line_start(line_start),
        .line_end(line_end), .vout_de(vout_de), .vout_data(vout_data),
        .line_cnt(line_cnt), .len_err(len_err), .err_cnt(err_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    logic        de_h [0:1023], fs_h [0:1023], ls_h [0:1023], le_h [0:1023], lerr_h [0:1023];
    logic [31:0] data_h [0:1023];
    logic [15:0] lc_h [0:1023], ec_h [0:1023];
    int ncyc = 0;
    int errors = 0;
    int checks = 0;
    int d_idx [0:7];

    initial begin
        forever begin
            @(negedge rx_clk);
            if (ncyc < 1024) begin
                de_h[ncyc] = vout_de;  fs_h[ncyc] = frame_start; ls_h[ncyc] = line_start;
                le_h[ncyc] = line_end; lerr_h[ncyc] = len_err;   data_h[ncyc] = vout_data;
                lc_h[ncyc] = line_cnt; ec_h[ncyc] = err_cnt;
            end
            ncyc++;
        end
    end

    function automatic int at(input int idx);
        return idx + LAT - 1;
    endfunction

    function automatic logic [31:0] pix(input int k);
        return {16'(2 * k + 2), 16'(2 * k + 1)};
    endfunction

    // Present one word for one clock; idx is the history slot of its LAT=1 result.
    task automatic send(input logic [31:0] d, input logic [3:0] c, output int idx);
        gt_rx_data = d;
        gt_rx_ctrl = c;
        idx = ncyc + 1;
        @(posedge rx_clk);
        #1;
    endtask

    task automatic tail();
        int t;
        send(W_IDLE0, CK, t);
        send(W_IDLE0, CK, t);
        repeat (2) @(negedge rx_clk);
        @(posedge rx_clk);
        #1;
    endtask

    task automatic send_line(input int n, output int i_ls, output int i_le);
        send(W_LSTART, CK, i_ls);
        for (int k = 0; k < n; k++) send(pix(k), CD, d_idx[k]);
        send(W_LEND, CK, i_le);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge rx_clk);
        #1;
        checks++; if ({frame_start, line_start, line_end, vout_de, len_err} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {frame_start, line_start, line_end, vout_de, len_err}); end
        checks++; if (vout_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", vout_data); end
        checks++; if (line_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL reset_counts: got lc=%0d ec=%0d want 0 0", line_cnt, err_cnt); end
        rst_n = 1'b1;
        @(posedge rx_clk);
        #1;
    endtask

    task automatic test_frame_sync();
        int i0, i1, i2, i3, n;
        send(W_IDLE0, CK, i0);
        send(W_SYNC0, CK, i1);
        send(W_SYNC1, CK, i2);
        send(W_IDLE0, CK, i3);
        tail();
        checks++; if (fs_h[at(i2)] !== 1'b1) begin errors++; $display("FAIL sync_fs: got %b want 1", fs_h[at(i2)]); end
        n = 0;
        for (int k = at(i0); k <= at(i3); k++) if (fs_h[k] === 1'b1) n++;
        checks++; if (n !== 1) begin errors++; $display("FAIL sync_fs_once: got %0d pulses want 1", n); end
        checks++; if (lc_h[at(i2)] !== 16'd0) begin errors++; $display("FAIL sync_lc: got %0d want 0", lc_h[at(i2)]); end
    endtask

    task automatic test_good_line();
        int i_ls, i_le;
        logic [31:0] exp_d [0:3];
        exp_d[0] = 32'h00020001; exp_d[1] = 32'h00040003;
        exp_d[2] = 32'h00060005; exp_d[3] = 32'h00080007;
        send_line(4, i_ls, i_le);
        tail();
        checks++; if (ls_h[at(i_ls)] !== 1'b1 || de_h[at(i_ls)] !== 1'b0) begin errors++; $display("FAIL good_ls: got ls=%b de=%b want 1 0", ls_h[at(i_ls)], de_h[at(i_ls)]); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (de_h[at(d_idx[k])] !== 1'b1 || data_h[at(d_idx[k])] !== exp_d[k]) begin errors++; $display("FAIL good_data%0d: got de=%b %h want 1 %h", k, de_h[at(d_idx[k])], data_h[at(d_idx[k])], exp_d[k]); end
        end
        checks++; if (le_h[at(i_le)] !== 1'b1 || lerr_h[at(i_le)] !== 1'b0 || de_h[at(i_le)] !== 1'b0) begin errors++; $display("FAIL good_le: got le=%b lerr=%b de=%b want 1 0 0", le_h[at(i_le)], lerr_h[at(i_le)], de_h[at(i_le)]); end
        checks++; if (lc_h[at(i_le)] !== 16'd1 || ec_h[at(i_le)] !== 16'd0) begin errors++; $display("FAIL good_counts: got lc=%0d ec=%0d want 1 0", lc_h[at(i_le)], ec_h[at(i_le)]); end
    endtask

    task automatic test_bad_length();
        int i_ls, i_le;
        send_line(3, i_ls, i_le);
        tail();
        checks++; if (lerr_h[at(i_le)] !== 1'b1 || le_h[at(i_le)] !== 1'b1) begin errors++; $display("FAIL short_lerr: got lerr=%b le=%b want 1 1", lerr_h[at(i_le)], le_h[at(i_le)]); end
        checks++; if (ec_h[at(i_le)] !== 16'd1 || lc_h[at(i_le)] !== 16'd2) begin errors++; $display("FAIL short_counts: got ec=%0d lc=%0d want 1 2", ec_h[at(i_le)], lc_h[at(i_le)]); end
        checks++; if (lerr_h[at(i_le) + 1] !== 1'b0) begin errors++; $display("FAIL short_pulse: got lerr=%b one cycle later want 0", lerr_h[at(i_le) + 1]); end
        send_line(5, i_ls, i_le);
        tail();
        checks++; if (lerr_h[at(i_le)] !== 1'b1) begin errors++; $display("FAIL long_lerr: got %b want 1", lerr_h[at(i_le)]); end
        checks++; if (ec_h[at(i_le)] !== 16'd2 || lc_h[at(i_le)] !== 16'd3) begin errors++; $display("FAIL long_counts: got ec=%0d lc=%0d want 2 3", ec_h[at(i_le)], lc_h[at(i_le)]); end
    endtask

    task automatic test_resync_midline();
        int i_ls, i0, i1, i2, t;
        send(W_LSTART, CK, i_ls);
        send(pix(0), CD, t);
        send(pix(1), CD, t);
        send(W_SYNC0, CK, i0);
        send(W_SYNC1, CK, i1);
        send(W_IDLE0, CK, i2);
        tail();
        checks++; if (lerr_h[at(i0)] !== 1'b1 || ec_h[at(i0)] !== 16'd3 || le_h[at(i0)] !== 1'b0) begin errors++; $display("FAIL resync_lerr: got lerr=%b ec=%0d le=%b want 1 3 0", lerr_h[at(i0)], ec_h[at(i0)], le_h[at(i0)]); end
        checks++; if (fs_h[at(i1)] !== 1'b1 || lc_h[at(i1)] !== 16'd0) begin errors++; $display("FAIL resync_fs: got fs=%b lc=%0d want 1 0", fs_h[at(i1)], lc_h[at(i1)]); end
        checks++; if ({de_h[at(i0)], de_h[at(i1)], de_h[at(i2)]} !== 3'b000) begin errors++; $display("FAIL resync_de: got %b want 000", {de_h[at(i0)], de_h[at(i1)], de_h[at(i2)]}); end
    endtask

    task automatic test_stray_data();
        int i0, i1;
        send(32'h12345678, CD, i0);
        send(32'h9ABCDEF0, CD, i1);
        tail();
        checks++; if (ec_h[at(i0)] !== 16'd4 || ec_h[at(i1)] !== 16'd5) begin errors++; $display("FAIL stray_ec: got %0d,%0d want 4,5", ec_h[at(i0)], ec_h[at(i1)]); end
        checks++; if (de_h[at(i0)] !== 1'b0 || de_h[at(i1)] !== 1'b0) begin errors++; $display("FAIL stray_de: got %b%b want 00", de_h[at(i0)], de_h[at(i1)]); end
    endtask

    task automatic test_abort_other_k();
        int i_ls, i_ab, i_le, t;
        send(W_LSTART, CK, i_ls);
        send(pix(0), CD, t);
        send(W_IDLE0, CK, i_ab);
        tail();
        checks++; if (lerr_h[at(i_ab)] !== 1'b1 || ec_h[at(i_ab)] !== 16'd6 || le_h[at(i_ab)] !== 1'b0 || lc_h[at(i_ab)] !== 16'd0) begin errors++; $display("FAIL abort: got lerr=%b ec=%0d le=%b lc=%0d want 1 6 0 0", lerr_h[at(i_ab)], ec_h[at(i_ab)], le_h[at(i_ab)], lc_h[at(i_ab)]); end
        send_line(4, i_ls, i_le);
        tail();
        checks++; if (le_h[at(i_le)] !== 1'b1 || lerr_h[at(i_le)] !== 1'b0 || lc_h[at(i_le)] !== 16'd1 || ec_h[at(i_le)] !== 16'd6) begin errors++; $display("FAIL after_abort: got le=%b lerr=%b lc=%0d ec=%0d want 1 0 1 6", le_h[at(i_le)], lerr_h[at(i_le)], lc_h[at(i_le)], ec_h[at(i_le)]); end
    endtask

    task automatic test_reset_midline();
        int t, i0, i3, i_s1, bad;
        send(W_SYNC0, CK, t);
        send(W_SYNC1, CK, t);
        send(W_LSTART, CK, t);
        send(pix(0), CD, t);
        send(pix(1), CD, t);
        rst_n = 1'b0;
        #1;
        checks++; if ({frame_start, line_start, line_end, vout_de, len_err} !== 5'b0 || vout_data !== 32'h0) begin errors++; $display("FAIL rst_mid_out: got %b %h want 00000 0", {frame_start, line_start, line_end, vout_de, len_err}, vout_data); end
        checks++; if (line_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt: got lc=%0d ec=%0d want 0 0", line_cnt, err_cnt); end
        repeat (2) @(posedge rx_clk);
        #1;
        rst_n = 1'b1;
        send(W_LSTART, CK, i0);
        send(pix(0), CD, t);
        send(pix(1), CD, t);
        send(W_LEND, CK, i3);
        tail();
        bad = 0;
        for (int k = at(i0); k <= at(i3) + 1; k++) if ({ls_h[k], de_h[k], le_h[k], lerr_h[k]} !== 4'b0 || ec_h[k] !== 16'd0) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rst_no_sync: got %0d active cycles want 0", bad); end
        send(W_SYNC0, CK, t);
        send(W_SYNC1, CK, i_s1);
        tail();
        checks++; if (fs_h[at(i_s1)] !== 1'b1 || lc_h[at(i_s1)] !== 16'd0) begin errors++; $display("FAIL rst_resync: got fs=%b lc=%0d want 1 0", fs_h[at(i_s1)], lc_h[at(i_s1)]); end
    endtask

`ifdef VIDEO_RECV_ALIGN_EN
    task automatic test_align();
        logic [31:0] lw [0:13];
        logic [3:0]  lc [0:13];
        int tidx [0:13];
        logic [31:0] pw;
        logic [3:0]  pc;
        lw[0] = W_IDLE0; lw[1] = W_IDLE0; lw[2] = W_SYNC0; lw[3] = W_SYNC1;
        lw[4] = W_IDLE0; lw[5] = W_LSTART;
        lw[6] = 32'h00020001; lw[7] = 32'h00040003; lw[8] = 32'h00060005; lw[9] = 32'h00080007;
        lw[10] = W_LEND; lw[11] = W_IDLE0; lw[12] = W_IDLE0; lw[13] = W_IDLE0;
        for (int i = 0; i < 14; i++) lc[i] = (i >= 6 && i <= 9) ? CD : CK;
        for (int j = 0; j < 14; j++) begin
            pw = (j == 0) ? W_IDLE0 : lw[j - 1];
            pc = (j == 0) ? 4'b0000 : lc[j - 1];
            send({lw[j][15:0], pw[31:16]}, {lc[j][1:0], pc[3:2]}, tidx[j]);
        end
        repeat (3) @(negedge rx_clk);
        @(posedge rx_clk);
        #1;
        checks++; if (fs_h[at(tidx[4])] !== 1'b1) begin errors++; $display("FAIL align_fs: got %b want 1", fs_h[at(tidx[4])]); end
        checks++; if (ls_h[at(tidx[6])] !== 1'b1) begin errors++; $display("FAIL align_ls: got %b want 1", ls_h[at(tidx[6])]); end
        for (int i = 6; i <= 9; i++) begin
            checks++; if (de_h[at(tidx[i + 1])] !== 1'b1 || data_h[at(tidx[i + 1])] !== lw[i]) begin errors++; $display("FAIL align_data%0d: got de=%b %h want 1 %h", i, de_h[at(tidx[i + 1])], data_h[at(tidx[i + 1])], lw[i]); end
        end
        checks++; if (le_h[at(tidx[11])] !== 1'b1 || lerr_h[at(tidx[11])] !== 1'b0 || lc_h[at(tidx[11])] !== 16'd1 || ec_h[at(tidx[11])] !== 16'd0) begin errors++; $display("FAIL align_le: got le=%b lerr=%b lc=%0d ec=%0d want 1 0 1 0", le_h[at(tidx[11])], lerr_h[at(tidx[11])], lc_h[at(tidx[11])], ec_h[at(tidx[11])]); end
    endtask
`endif

    initial begin
        vin_width = 16'd8;
        test_reset();
        test_frame_sync();
        test_good_line();
        test_bad_length();
        test_resync_midline();
        test_stray_data();
        test_abort_other_k();
        test_reset_midline();
`ifdef VIDEO_RECV_ALIGN_EN
        test_align();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_packet_recv.md
Name: video_packet_recv

Overview:
Receive-side counterpart of the video packet sender on the GT/SFP link. Consumes the 32-bit data / 4-bit K-control word stream from the GT receiver in the rx_clk domain. Decodes frame-sync, line-start, line-end and idle K-words, and emits a registered 32-bit pixel-pair stream with frame and line strobes. Downstream, a width-converting FIFO and the frame buffer writer consume this stream.

Parameters:
WIDTH_W, 16, width of the expected-line-width input and of the line and error counters.
ERR_CNT_SAT, 1, 1 = error counter saturates at all-ones; 0 = error counter wraps.

Ports:
rx_clk  input  1  GT receive user clock; all logic in this domain.
rst_n  input  1  asynchronous active-low reset.
gt_rx_data  input  32  received word; byte0 carries the K character when ctrl[0]=1.
gt_rx_ctrl  input  4  per-byte K flag.
vin_width  input  WIDTH_W  expected pixels per line; even value; quasi-static.
frame_start  output  1  one-cycle pulse on a decoded frame sync.
line_start  output  1  one-cycle pulse on LINE_START.
line_end  output  1  one-cycle pulse on LINE_END.
vout_de  output  1  vout_data valid.
vout_data  output  32  two pixels; [15:0] is the earlier pixel, [31:16] the later.
line_cnt  output  WIDTH_W  lines received since the last frame_start.
len_err  output  1  one-cycle pulse on a bad line length or an aborted line.
err_cnt  output  WIDTH_W  accumulated protocol errors.

Behaviour:
- Control words (ctrl==4'b0001, byte0==8'hBC): SYNC0=ff_00_00_bc, SYNC1=ff_00_01_bc, LSTART=ff_00_02_bc, LEND=ff_00_03_bc, IDLE0=ff_55_55_bc, IDLE1=ff_aa_aa_bc. Any other word with ctrl!=0 is UNKNOWN_K. ctrl==0 is a DATA word.
- Reset: all outputs 0; state SEARCH; counters 0.
- All outputs are registered: latency of 1 rx_clk from input word to output.
- States and transitions:
  - SEARCH: SYNC0 -> GOT_S0. All other words are ignored.
  - GOT_S0: SYNC1 -> pulse frame_start, clear line_cnt, go to WAIT_LINE. SYNC0 -> stay. Anything else -> SEARCH, no error.
  - WAIT_LINE: LSTART -> pulse line_start, clear word_cnt, go to LINE. IDLE0/IDLE1 -> stay. DATA -> err++, stay. SYNC0 -> GOT_S0.
  - LINE: DATA -> vout_de=1, vout_data=word, word_cnt++. LEND -> pulse line_end, line_cnt++, go to WAIT_LINE; if word_cnt != vin_width>>1, pulse len_err and err++. SYNC0 -> abort the line: len_err, err++, go to GOT_S0. Any other control word -> abort: len_err, err++, go to WAIT_LINE.
- word_cnt is WIDTH_W bits and saturates at all-ones, so an overlong line still flags an error on LEND.
- line_cnt wraps.
- err_cnt saturates or wraps per ERR_CNT_SAT. At most one increment per cycle.
- A frame sync pair (SYNC0 then SYNC1) is honoured from every state, including mid-line; this resynchronises the receiver.
- vout_de is never asserted outside the LINE state.
- Reset asserted mid-line drops the line with no pulses; after release, the block waits for a full frame sync.

Optional Feature:
VIDEO_RECV_ALIGN_EN.
- Defined: an alignment stage ahead of decode. When ctrl is one-hot at byte k (k=1..3) with byte k==8'hBC, the stage locks offset k. Each word is then rebuilt from the previous word's upper bytes and the current word's lower bytes (ctrl rebuilt the same way), so the K byte lands in byte0. The lock is updated on every IDLE0/IDLE1 seen at a new offset. Adds 1 cycle of latency (2 total).
- Undefined: no alignment stage. Only byte0 K characters are recognised; misaligned control words are UNKNOWN_K.

Decomposition:
- Shared package video_link_pkg: K-word constants (SYNC0, SYNC1, LSTART, LEND, IDLE0, IDLE1), the K-character value 8'hBC, the state enum, and a word-classify function. The sender is refactored to use the same package.
- Sub-module gt_word_align holds the alignment stage. It is instantiated only under VIDEO_RECV_ALIGN_EN.

Test Plan:
- SYNC0, SYNC1, then IDLE -> frame_start pulses exactly once, 1 cycle after SYNC1; line_cnt=0.
- vin_width=8; LSTART, 4 DATA words (0x00020001..0x00080007), LEND -> 4 de cycles with matching data; line_end; line_cnt=1; no len_err.
- vin_width=8; line with 3 DATA words -> len_err pulse on LEND; err_cnt=1. Repeat with 5 words -> err_cnt=2.
- SYNC0, SYNC1 injected after 2 DATA words of a line -> len_err; frame_start 1 cycle after SYNC1; line_cnt=0; vout_de low afterward.
- DATA words in WAIT_LINE, and rst_n pulsed low mid-line -> no de; err_cnt increments per stray word; all outputs 0 after reset.
- With VIDEO_RECV_ALIGN_EN: stream rotated by 2 bytes (IDLE arrives as ctrl=4'b0100) -> lock acquired; subsequent line data reproduced exactly with 2-cycle latency.
